ahb_lite_sram_bridge: RTL and testbench

//  AHB-Lite slave that converts bus transfers into single-port SRAM accesses for the on-chip

---
 rtl/ahb_sram_pkg.sv | 39 +++
 rtl/ahb_sram_wbuf.sv | 60 ++++++
 rtl/ahb_lite_sram_bridge.sv | 88 ++++++++
 tb/tb_ahb_lite_sram_bridge.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/ahb_sram_pkg.sv
// Shared encodings, write-buffer entry type and lane decode for the AHB-Lite SRAM bridge.
package ahb_sram_pkg;

  localparam int SRAM_AW   = 16;
  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'b00,
    TRANS_BUSY   = 2'b01,
    TRANS_NONSEQ = 2'b10,
    TRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    SIZE_BYTE = 3'd0,
    SIZE_HALF = 3'd1,
    SIZE_WORD = 3'd2
  } hsize_e;

  typedef struct packed {
    logic [SRAM_AW-1:0]   addr;
    logic [NUM_LANES-1:0] mask;
    logic [31:0]          data;
  } wb_entry_t;

  function automatic logic trans_valid(input logic [1:0] t);
    return (t == TRANS_NONSEQ) || (t == TRANS_SEQ);
  endfunction

  // Oversized transfers collapse to a full-word access.
  function automatic logic [NUM_LANES-1:0] lane_mask(input logic [2:0] size, input logic [1:0] a);
    case (size)
      SIZE_BYTE: lane_mask = 4'b0001 << a;
      SIZE_HALF: lane_mask = a[1] ? 4'b1100 : 4'b0011;
      default:   lane_mask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/ahb_sram_wbuf.sv
// Two-entry write FIFO with a byte-merge lookup so reads see not-yet-drained writes.
module ahb_sram_wbuf
  import ahb_sram_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  wb_entry_t          push_ent,
  input  logic               pop,
  output wb_entry_t          head,
  output logic               empty,
  input  logic [SRAM_AW-1:0] qaddr,
  input  logic [31:0]        qbase,
  output logic [31:0]        qdata
);

  wb_entry_t  ent [2];
  logic       wptr, rptr;
  logic [1:0] cnt;
  logic       full;

  assign empty = (cnt == 2'd0);
  assign full  = (cnt == 2'd2);
  assign head  = ent[rptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= 1'b0;
      rptr <= 1'b0;
      cnt  <= 2'd0;
    end else begin
      if (push) begin
        ent[wptr] <= push_ent;
        wptr      <= ~wptr;
      end
      if (pop) rptr <= ~rptr;
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));

  // Older entry sits at rptr; the younger one (only when full) overrides it per byte.
  wb_entry_t yng_e;
  logic      old_match, yng_match;
  assign yng_e     = ent[~rptr];
  assign old_match = ~empty && (head.addr == qaddr);
  assign yng_match = full && (yng_e.addr == qaddr);

  logic [NUM_LANES-1:0][7:0] qbytes;
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic old_hit, yng_hit;
    assign old_hit   = old_match && head.mask[l];
    assign yng_hit   = yng_match && yng_e.mask[l];
    assign qbytes[l] = yng_hit ? yng_e.data[8*l +: 8] :
                       old_hit ? head.data[8*l +: 8]  : qbase[8*l +: 8];
  end
  assign qdata = qbytes;

endmodule

// File: rtl/ahb_lite_sram_bridge.sv
// Zero-wait AHB-Lite slave onto a single-port block RAM; writes are buffered and drained
// whenever the bus is not reading, reads are merged with buffered bytes.
module ahb_lite_sram_bridge
  import ahb_sram_pkg::*;
#(
  parameter int AW = 16
) (
  input  logic          HCLK,
  input  logic          HRESET,
  input  logic          HSEL,
  input  logic [AW+1:0] HADDR,
  input  logic [1:0]    HTRANS,
  input  logic [2:0]    HSIZE,
  input  logic          HWRITE,
  input  logic [31:0]   HWDATA,
  input  logic          HREADY,
  output logic          HREADYOUT,
  output logic          HRESP,
  output logic [31:0]   HRDATA,
  input  logic [31:0]   SRAMRDATA,
  output logic [AW-1:0] SRAMADDR,
  output logic [31:0]   SRAMWDATA,
  output logic [3:0]    SRAMWEN,
  output logic          SRAMCS
);

  if (AW > SRAM_AW) begin : g_aw_check
    $error("AW exceeds the write-buffer address field width");
  end

  logic          valid, rd_ap, wr_ap, drain, push;
  logic          wr_dp, rd_dp;
  logic [AW-1:0] pend_addr, rd_addr;
  logic [3:0]    pend_mask;
  wb_entry_t     push_ent, head;
  logic          empty;
  logic [31:0]   merged;

  // Reset masks every address phase so nothing reaches the SRAM while HRESET is high.
  assign valid = ~HRESET & HSEL & HREADY & trans_valid(HTRANS);
  assign rd_ap = valid & ~HWRITE;
  assign wr_ap = valid & HWRITE;
  assign drain = ~HRESET & ~rd_ap & ~empty;
  assign push  = wr_dp & HREADY;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      wr_dp     <= 1'b0;
      rd_dp     <= 1'b0;
      pend_addr <= '0;
      pend_mask <= '0;
      rd_addr   <= '0;
    end else if (HREADY) begin
      wr_dp <= wr_ap;
      rd_dp <= rd_ap;
      if (wr_ap) begin
        pend_addr <= HADDR[AW+1:2];
        pend_mask <= lane_mask(HSIZE, HADDR[1:0]);
      end
      if (rd_ap) rd_addr <= HADDR[AW+1:2];
    end
  end

  assign push_ent = '{addr: SRAM_AW'(pend_addr), mask: pend_mask, data: HWDATA};

  ahb_sram_wbuf u_wbuf (
    .clk      (HCLK),
    .rst      (HRESET),
    .push     (push),
    .push_ent (push_ent),
    .pop      (drain),
    .head     (head),
    .empty    (empty),
    .qaddr    (SRAM_AW'(rd_addr)),
    .qbase    (SRAMRDATA),
    .qdata    (merged)
  );

  assign SRAMCS    = rd_ap | drain;
  assign SRAMADDR  = rd_ap ? HADDR[AW+1:2] : head.addr[AW-1:0];
  assign SRAMWDATA = head.data;
  assign SRAMWEN   = drain ? head.mask : 4'b0000;

  assign HRDATA    = (rd_dp & ~HRESET) ? merged : 32'h0;
  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;

endmodule

// File: tb/tb_ahb_lite_sram_bridge.sv
// Directed bench for ahb_lite_sram_bridge: a driver queues expected reads/SRAM writes,
// a negedge monitor pops and compares them against what the bridge presents.
module tb_ahb_lite_sram_bridge;

  localparam int AW = 16;
  localparam logic [1:0] NS = 2'b10;
  localparam logic [1:0] ID = 2'b00;

  logic          HCLK = 1'b0, HRESET = 1'b1, HSEL = 1'b0, HWRITE = 1'b0, HREADY = 1'b1;
  logic [AW+1:0] HADDR = '0;
  logic [1:0]    HTRANS = 2'b00;
  logic [2:0]    HSIZE = 3'd0;
  logic [31:0]   HWDATA = 32'h0;
  logic          HREADYOUT, HRESP, SRAMCS;
  logic [31:0]   HRDATA, SRAMRDATA, SRAMWDATA;
  logic [AW-1:0] SRAMADDR;
  logic [3:0]    SRAMWEN;

  ahb_lite_sram_bridge #(.AW(AW)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HSIZE(HSIZE), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA), .SRAMRDATA(SRAMRDATA),
    .SRAMADDR(SRAMADDR), .SRAMWDATA(SRAMWDATA), .SRAMWEN(SRAMWEN), .SRAMCS(SRAMCS)
  );

  always #5 HCLK = ~HCLK;

  // Block-RAM model: registered read data, zero unless the previous cycle was a read.
  bit [31:0]   mem [0:1023];
  bit          written [0:1023];
  logic [31:0] sram_q = 32'h0;
  logic        sram_rv = 1'b0;

  function automatic logic [31:0] init_word(input int a);
    case (a)
      2:       return 32'h88888888;
      3:       return 32'hCCCCCCCC;
      4:       return 32'h0BADF00D;
      5:       return 32'h0000CAFE;
      'h80:    return 32'h12345678;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] cur_word(input int a);
    return written[a] ? mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] merge_w(input logic [31:0] o, input logic [31:0] n, input logic [3:0] we);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (we[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  always @(posedge HCLK) begin
    sram_rv <= SRAMCS && (SRAMWEN == 4'b0);
    if (SRAMCS && SRAMWEN == 4'b0) sram_q <= cur_word(int'(SRAMADDR[9:0]));
    if (SRAMCS && SRAMWEN != 4'b0) begin
      mem[SRAMADDR[9:0]]     <= merge_w(cur_word(int'(SRAMADDR[9:0])), SRAMWDATA, SRAMWEN);
      written[SRAMADDR[9:0]] <= 1'b1;
    end
  end
  assign SRAMRDATA = sram_rv ? sram_q : 32'h0;

  // Scoreboard
  int          tests = 0, fails = 0;
  logic [31:0] rd_q [$];
  logic [51:0] wr_q [$];
  logic        in_rst = 1'b1, rd_phase = 1'b0, rd_ap_now = 1'b0, pend_rd = 1'b0;
  logic [15:0] rd_ap_addr = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic exp_rd(input logic [31:0] d);
    rd_q.push_back(d);
  endtask

  task automatic exp_wr(input logic [15:0] a, input logic [3:0] we, input logic [31:0] d);
    wr_q.push_back({a, we, d});
  endtask

  task automatic bus(input logic rst, input logic [1:0] tr, input logic wr, input logic [2:0] sz,
                     input logic [17:0] a, input logic [31:0] wd);
    @(posedge HCLK); #1;
    HRESET = rst; HSEL = 1'b1; HREADY = 1'b1; HTRANS = tr; HWRITE = wr;
    HSIZE = sz; HADDR = a; HWDATA = wd;
    in_rst     = rst;
    rd_phase   = pend_rd && !rst;
    rd_ap_now  = !rst && tr[1] && !wr;
    rd_ap_addr = a[17:2];
    pend_rd    = rd_ap_now;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) bus(1'b0, ID, 1'b0, 3'd0, 18'h0, 32'h0);
  endtask

  logic [31:0] m_rd;
  logic [51:0] m_wr;
  always @(negedge HCLK) begin
    chk("hreadyout", 64'(HREADYOUT), 64'd1);
    chk("hresp", 64'(HRESP), 64'd0);
    if (in_rst) begin
      chk("rst_sramcs", 64'(SRAMCS), 64'd0);
      chk("rst_sramwen", 64'(SRAMWEN), 64'd0);
      chk("rst_hrdata", 64'(HRDATA), 64'd0);
    end else begin
      if (rd_phase) begin
        if (rd_q.size() == 0) chk("rd_unexpected", 64'(HRDATA), 64'hFFFF_FFFF_FFFF_FFFF);
        else begin
          m_rd = rd_q.pop_front();
          chk("hrdata", 64'(HRDATA), 64'(m_rd));
        end
      end else chk("hrdata_idle", 64'(HRDATA), 64'd0);
      if (rd_ap_now) begin
        chk("rd_sramcs", 64'(SRAMCS), 64'd1);
        chk("rd_sramaddr", 64'(SRAMADDR), 64'(rd_ap_addr));
        chk("rd_no_write", 64'(SRAMWEN), 64'd0);
      end else if (SRAMCS && SRAMWEN != 4'b0) begin
        if (wr_q.size() == 0) chk("wr_unexpected", {SRAMADDR, SRAMWEN, SRAMWDATA}, 64'hFFFF_FFFF_FFFF_FFFF);
        else begin
          m_wr = wr_q.pop_front();
          chk("sram_write", {SRAMADDR, SRAMWEN, SRAMWDATA}, 64'(m_wr));
        end
      end
    end
  end

  initial begin
    // Reset held with a live NONSEQ read on the bus
    for (int i = 0; i < 3; i++) bus(1'b1, NS, 1'b0, 3'd2, 18'h100, 32'h0);
    idle(2);

    // Word write, drained on the following idle cycles
    exp_wr(16'h0040, 4'hF, 32'hDEADBEEF);
    bus(1'b0, NS, 1'b1, 3'd2, 18'h100, 32'h0);
    bus(1'b0, ID, 1'b0, 3'd0, 18'h0, 32'hDEADBEEF);
    idle(3);

    // Byte write then back-to-back read: top byte merged from the buffer
    exp_wr(16'h0040, 4'b1000, 32'hA5000000);
    exp_rd(32'hA5ADBEEF);
    bus(1'b0, NS, 1'b1, 3'd0, 18'h103, 32'h0);
    bus(1'b0, NS, 1'b0, 3'd2, 18'h100, 32'hA5000000);
    idle(4);

    // W,W,R,R: buffer fills to 2, reads block drain, writes land in order afterwards
    exp_wr(16'h0000, 4'hF, 32'h01010101);
    exp_wr(16'h0001, 4'hF, 32'h02020202);
    exp_rd(32'h88888888);
    exp_rd(32'hCCCCCCCC);
    bus(1'b0, NS, 1'b1, 3'd2, 18'h000, 32'h0);
    bus(1'b0, NS, 1'b1, 3'd2, 18'h004, 32'h01010101);
    bus(1'b0, NS, 1'b0, 3'd2, 18'h008, 32'h02020202);
    bus(1'b0, NS, 1'b0, 3'd2, 18'h00C, 32'h0);
    idle(4);

    // Upper halfword write, merged read, then read back from SRAM
    exp_wr(16'h0080, 4'b1100, 32'hBEEF0000);
    exp_rd(32'hBEEF5678);
    bus(1'b0, NS, 1'b1, 3'd1, 18'h202, 32'h0);
    bus(1'b0, NS, 1'b0, 3'd2, 18'h200, 32'hBEEF0000);
    idle(3);
    exp_rd(32'hBEEF5678);
    bus(1'b0, NS, 1'b0, 3'd2, 18'h200, 32'h0);
    idle(2);

    // Two buffered writes to one word: younger bytes win in the merge
    exp_wr(16'h0008, 4'b0010, 32'h00001100);
    exp_wr(16'h0008, 4'b0011, 32'h00002233);
    exp_rd(32'h00002233);
    bus(1'b0, NS, 1'b1, 3'd0, 18'h021, 32'h0);
    bus(1'b0, NS, 1'b1, 3'd1, 18'h020, 32'h00001100);
    bus(1'b0, NS, 1'b0, 3'd2, 18'h020, 32'h00002233);
    idle(4);

    // Reset with two writes buffered: they must never reach SRAM
    bus(1'b0, NS, 1'b1, 3'd2, 18'h010, 32'h0);
    bus(1'b0, NS, 1'b1, 3'd2, 18'h014, 32'hAAAAAAAA);
    bus(1'b0, NS, 1'b0, 3'd2, 18'h018, 32'h55555555);
    bus(1'b1, ID, 1'b0, 3'd0, 18'h0, 32'h0);
    idle(4);
    exp_rd(32'h0BADF00D);
    exp_rd(32'h0000CAFE);
    bus(1'b0, NS, 1'b0, 3'd2, 18'h010, 32'h0);
    bus(1'b0, NS, 1'b0, 3'd2, 18'h014, 32'h0);
    idle(3);

    chk("wr_q_drained", 64'(wr_q.size()), 64'd0);
    chk("rd_q_drained", 64'(rd_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
